// File: rtl/stencil_seq_pkg.sv
// Shared types for the stencil frame sequencer: FSM states, minimum
// accepted frame dimension and the 32-bit pixel/output count type.
package stencil_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        STREAM,
        DRAIN,
        DONE
    } seq_state_t;

    // Smallest width/height that still yields at least one 3x3 output.
    localparam logic [15:0] MIN_DIM = 16'd3;

    typedef logic [31:0] count_t;

endpackage

// File: rtl/stencil_frame_sequencer_if.sv
// Kernel channels plus source/destination RAM ports of the sequencer.
// master = sequencer side, slave = kernel and RAM side.
interface stencil_frame_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int PIX_W  = 8
);
    logic              src_rd_en;
    logic [ADDR_W-1:0] src_rd_addr;
    logic [PIX_W-1:0]  src_rd_data;

    logic              k_imgw_valid;
    logic              k_imgw_ready;
    logic [15:0]       k_imgw_bits;
    logic              k_imgh_valid;
    logic              k_imgh_ready;
    logic [15:0]       k_imgh_bits;

    logic              k_pixel_valid;
    logic              k_pixel_ready;
    logic [PIX_W-1:0]  k_pixel_bits;

    logic              k_out_valid;
    logic              k_out_ready;
    logic [PIX_W-1:0]  k_out_bits;

    logic              dst_wr_en;
    logic [ADDR_W-1:0] dst_wr_addr;
    logic [PIX_W-1:0]  dst_wr_data;

    modport master (
        output src_rd_en, src_rd_addr, input src_rd_data,
        output k_imgw_valid, k_imgw_bits, input k_imgw_ready,
        output k_imgh_valid, k_imgh_bits, input k_imgh_ready,
        output k_pixel_valid, k_pixel_bits, input k_pixel_ready,
        input  k_out_valid, k_out_bits, output k_out_ready,
        output dst_wr_en, dst_wr_addr, dst_wr_data
    );

    modport slave (
        input  src_rd_en, src_rd_addr, output src_rd_data,
        input  k_imgw_valid, k_imgw_bits, output k_imgw_ready,
        input  k_imgh_valid, k_imgh_bits, output k_imgh_ready,
        input  k_pixel_valid, k_pixel_bits, output k_pixel_ready,
        output k_out_valid, k_out_bits, input k_out_ready,
        input  dst_wr_en, dst_wr_addr, dst_wr_data
    );
endinterface

// File: rtl/stencil_seq_skid.sv
// Two-entry ready/valid buffer for the pixel path. The producer never
// pushes into a full buffer (it meters reads against the occupancy
// count), so there is no in_ready. head_q always holds the entry on the
// output, so out_bits cannot change while out_valid is high and
// out_ready is low.
module stencil_seq_skid #(
    parameter int PIX_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_bits,
    output logic [1:0]       occupancy
);
    logic [1:0]       count_q, count_d;
    logic [PIX_W-1:0] head_q, head_d;
    logic [PIX_W-1:0] tail_q, tail_d;
    logic             pop;

    assign out_valid = (count_q != 2'd0);
    assign out_bits  = head_q;
    assign occupancy = count_q;

    // Next occupancy and entry contents from push/pop of this cycle.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        pop     = out_valid && out_ready;
        case (count_q)
            2'd0: begin
                if (in_valid) begin
                    head_d  = in_bits;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (pop && in_valid) begin
                    head_d = in_bits;
                end else if (pop) begin
                    count_d = 2'd0;
                end else if (in_valid) begin
                    tail_d  = in_bits;
                    count_d = 2'd2;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (in_valid) begin
                        tail_d = in_bits;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
        endcase
        if (flush) begin
            count_d = 2'd0;
        end
    end

    // Occupancy register; reset and flush empty the buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful under the count.
    always_ff @(posedge clock) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end
endmodule

// File: rtl/stencil_frame_sequencer.sv
// Frame sequencer for a 3x3 stencil kernel: sends W/H to the kernel,
// streams W*H source pixels in raster order through a 2-entry skid
// buffer and writes the (W-2)*(H-2) results to the destination RAM.
// Optional build macro STENCIL_SEQ_TIMEOUT_EN adds a STREAM/DRAIN
// watchdog that aborts the frame with an error pulse after TIMEOUT
// cycles without a kernel output.
module stencil_frame_sequencer
    import stencil_seq_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int PIX_W   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       cfg_width,
    input  logic [15:0]       cfg_height,
    input  logic [ADDR_W-1:0] cfg_src_base,
    input  logic [ADDR_W-1:0] cfg_dst_base,
    output logic              busy,
    output logic              done,
    output logic              error,
    stencil_frame_sequencer_if.master bus
);
    seq_state_t        state_q, state_d;
    logic [15:0]       w_q, w_d, h_q, h_d;
    logic [ADDR_W-1:0] src_base_q, src_base_d, dst_base_q, dst_base_d;
    count_t            total_pix_q, total_pix_d, total_out_q, total_out_d;
    count_t            rd_cnt_q, rd_cnt_d, pix_cnt_q, pix_cnt_d, out_cnt_q, out_cnt_d;
    logic              imgw_vld_q, imgw_vld_d, imgh_vld_q, imgh_vld_d;
    logic              inflight_q, inflight_d;
    logic              error_q, error_d;
    logic              flush, rd_en, pix_hs, out_hs, out_ready;
    logic [2:0]        credit;
    logic [1:0]        occ;
`ifdef STENCIL_SEQ_TIMEOUT_EN
    count_t            wd_q, wd_d;
`else
    // TIMEOUT only matters when the watchdog is built in.
    wire [31:0]        unused_timeout = 32'(TIMEOUT);
`endif

    assign out_ready         = (state_q == STREAM) || (state_q == DRAIN);
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);
    assign error             = error_q;
    assign bus.k_imgw_valid  = imgw_vld_q;
    assign bus.k_imgw_bits   = w_q;
    assign bus.k_imgh_valid  = imgh_vld_q;
    assign bus.k_imgh_bits   = h_q;
    assign bus.k_out_ready   = out_ready;
    assign bus.src_rd_en     = rd_en;
    assign bus.src_rd_addr   = src_base_q + rd_cnt_q[ADDR_W-1:0];
    assign bus.dst_wr_en     = out_hs;
    assign bus.dst_wr_addr   = dst_base_q + out_cnt_q[ADDR_W-1:0];
    assign bus.dst_wr_data   = bus.k_out_bits;

    stencil_seq_skid #(.PIX_W(PIX_W)) u_skid (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (inflight_q),
        .in_bits   (bus.src_rd_data),
        .out_valid (bus.k_pixel_valid),
        .out_ready (bus.k_pixel_ready),
        .out_bits  (bus.k_pixel_bits),
        .occupancy (occ)
    );

    // Next-state, counters, read metering and pulse generation.
    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        h_d         = h_q;
        src_base_d  = src_base_q;
        dst_base_d  = dst_base_q;
        total_pix_d = total_pix_q;
        total_out_d = total_out_q;
        rd_cnt_d    = rd_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        out_cnt_d   = out_cnt_q;
        imgw_vld_d  = imgw_vld_q;
        imgh_vld_d  = imgh_vld_q;
        error_d     = 1'b0;
        flush       = 1'b0;
        pix_hs      = bus.k_pixel_valid && bus.k_pixel_ready;
        out_hs      = bus.k_out_valid && out_ready;
        // Credit counts the entry leaving this cycle as free, which keeps
        // one read per cycle going while the kernel accepts every pixel.
        credit      = 3'(occ) - 3'(pix_hs) + 3'(inflight_q);
        rd_en       = (state_q == STREAM) && (rd_cnt_q < total_pix_q) && (credit < 3'd2);
        if (rd_en) begin
            rd_cnt_d = rd_cnt_q + 1;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((cfg_width < MIN_DIM) || (cfg_height < MIN_DIM)) begin
                        error_d = 1'b1;
                    end else begin
                        w_d         = cfg_width;
                        h_d         = cfg_height;
                        src_base_d  = cfg_src_base;
                        dst_base_d  = cfg_dst_base;
                        total_pix_d = count_t'(cfg_width) * count_t'(cfg_height);
                        total_out_d = count_t'(cfg_width - 16'd2) * count_t'(cfg_height - 16'd2);
                        rd_cnt_d    = '0;
                        pix_cnt_d   = '0;
                        out_cnt_d   = '0;
                        imgw_vld_d  = 1'b1;
                        imgh_vld_d  = 1'b1;
                        state_d     = CFG;
                    end
                end
            end
            CFG: begin
                if (bus.k_imgw_ready) imgw_vld_d = 1'b0;
                if (bus.k_imgh_ready) imgh_vld_d = 1'b0;
                if (!imgw_vld_d && !imgh_vld_d) state_d = STREAM;
            end
            STREAM: begin
                if (pix_hs) pix_cnt_d = pix_cnt_q + 1;
                if (out_hs) out_cnt_d = out_cnt_q + 1;
                if (pix_hs && (pix_cnt_q == total_pix_q - 1)) begin
                    state_d = (out_cnt_d == total_out_q) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs) out_cnt_d = out_cnt_q + 1;
                if (out_cnt_d == total_out_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef STENCIL_SEQ_TIMEOUT_EN
        wd_d = '0;
        if (out_ready) begin
            wd_d = out_hs ? '0 : wd_q + 1;
            if (!out_hs && (wd_q == count_t'(TIMEOUT - 1)) && (state_d != DONE)) begin
                error_d = 1'b1;
                flush   = 1'b1;
                state_d = IDLE;
                wd_d    = '0;
            end
        end
`endif
        inflight_d = rd_en && !flush;
    end

    // Control state: FSM, counters, channel valids and pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            pix_cnt_q  <= '0;
            out_cnt_q  <= '0;
            imgw_vld_q <= 1'b0;
            imgh_vld_q <= 1'b0;
            inflight_q <= 1'b0;
            error_q    <= 1'b0;
`ifdef STENCIL_SEQ_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            out_cnt_q  <= out_cnt_d;
            imgw_vld_q <= imgw_vld_d;
            imgh_vld_q <= imgh_vld_d;
            inflight_q <= inflight_d;
            error_q    <= error_d;
`ifdef STENCIL_SEQ_TIMEOUT_EN
            wd_q       <= wd_d;
`endif
        end
    end

    // Frame configuration captured on an accepted start.
    always_ff @(posedge clock) begin
        w_q         <= w_d;
        h_q         <= h_d;
        src_base_q  <= src_base_d;
        dst_base_q  <= dst_base_d;
        total_pix_q <= total_pix_d;
        total_out_q <= total_out_d;
    end
endmodule

// File: tb/tb_stencil_frame_sequencer.sv
// Bench for stencil_frame_sequencer: source/destination RAM models and a
// 3x3 Gaussian kernel stub that emits each output as soon as its window
// pixels have arrived.
module tb_stencil_frame_sequencer;
    localparam int ADDR_W  = 16;
    localparam int PIX_W   = 8;
    localparam int TIMEOUT = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [15:0]       cfg_width, cfg_height;
    logic [ADDR_W-1:0] cfg_src_base, cfg_dst_base;
    logic              busy, done, error;

    stencil_frame_sequencer_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus();

    stencil_frame_sequencer #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
        .busy(busy), .done(done), .error(error), .bus(bus)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;
    int rd_count = 0, wr_count = 0, imgw_hs_cnt = 0, imgh_hs_cnt = 0;
    int done_cnt = 0, err_cnt = 0, stall_bad = 0;
    int kpix_cnt = 0, kout_idx = 0, kw = 0, kh = 0;
    int kpix [0:1023];
    bit ready_random = 1'b0, never_out = 1'b0;
    bit prev_stall = 1'b0, rd_pend = 1'b0, h_seen = 1'b0;
    logic [7:0]  prev_bits;
    logic [15:0] rd_addr_s;
    logic [7:0]  src_ram [0:65535];
    logic [7:0]  dst_ram [0:65535];
    int img [0:15] = '{0, 0, 0, 0, 0, 16, 64, 0, 0, 32, 128, 0, 0, 0, 0, 0};
    logic [7:0] exp_px [0:3] = '{8'd24, 8'd36, 8'd30, 8'd45};

    function automatic int gauss(int idx);
        int r, c, s;
        c = idx % (kw - 2);
        r = idx / (kw - 2);
        s = 0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                s += kpix[(r + dy) * kw + c + dx] * ((dy == 1) ? 2 : 1) * ((dx == 1) ? 2 : 1);
        return s >> 4;
    endfunction

    function automatic int need_pix(int idx);
        return (idx / (kw - 2) + 2) * kw + (idx % (kw - 2)) + 3;
    endfunction

    // Environment: observe at negedge, respond 1 time unit after posedge.
    initial begin
        bus.src_rd_data = '0;  bus.k_imgw_ready = 1'b0; bus.k_imgh_ready = 1'b0;
        bus.k_pixel_ready = 1'b0; bus.k_out_valid = 1'b0; bus.k_out_bits = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                kpix_cnt = 0; kout_idx = 0; kw = 0; kh = 0;
                prev_stall = 1'b0; rd_pend = 1'b0; h_seen = 1'b0;
            end else begin
                rd_pend = bus.src_rd_en;
                rd_addr_s = bus.src_rd_addr;
                if (bus.src_rd_en) rd_count++;
                if (bus.dst_wr_en) begin
                    dst_ram[bus.dst_wr_addr] = bus.dst_wr_data;
                    wr_count++;
                end
                if (bus.k_imgw_valid && bus.k_imgw_ready) begin
                    kw = int'(bus.k_imgw_bits); kpix_cnt = 0; kout_idx = 0; imgw_hs_cnt++;
                end
                if (bus.k_imgh_valid && bus.k_imgh_ready) begin
                    kh = int'(bus.k_imgh_bits); imgh_hs_cnt++;
                end
                h_seen = bus.k_imgh_valid && !bus.k_imgh_ready;
                if (prev_stall && (!bus.k_pixel_valid || bus.k_pixel_bits !== prev_bits)) stall_bad++;
                prev_stall = bus.k_pixel_valid && !bus.k_pixel_ready;
                prev_bits = bus.k_pixel_bits;
                if (bus.k_pixel_valid && bus.k_pixel_ready) begin
                    if (kpix_cnt < 1024) kpix[kpix_cnt] = int'(bus.k_pixel_bits);
                    kpix_cnt++;
                end
                if (bus.k_out_valid && bus.k_out_ready) kout_idx++;
                if (done) done_cnt++;
                if (error) err_cnt++;
            end
            @(posedge clock);
            #1;
            if (rd_pend) bus.src_rd_data = src_ram[rd_addr_s];
            bus.k_imgw_ready = 1'b1;
            bus.k_imgh_ready = h_seen;
            bus.k_pixel_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!never_out && kw >= 3 && kh >= 3 && kout_idx < (kw - 2) * (kh - 2)
                && kpix_cnt >= need_pix(kout_idx)) begin
                bus.k_out_valid = 1'b1;
                bus.k_out_bits = 8'(gauss(kout_idx));
            end else begin
                bus.k_out_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input int w, input int h);
        tick();
        cfg_width = 16'(w); cfg_height = 16'(h); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic load_frame();
        for (int i = 0; i < 16; i++) src_ram[16'(16 + i)] = 8'(img[i]);
        for (int i = 0; i < 20; i++) dst_ram[16'(124 + i)] = 8'hEE;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        reset = 1'b1;
        repeat (3) tick();
        obs = {busy, done, error, bus.k_out_ready, bus.src_rd_en, bus.dst_wr_en,
               bus.k_pixel_valid, bus.k_imgw_valid, bus.k_imgh_valid};
        checks++;
        if (obs !== 9'd0) begin failures++; $display("FAIL reset_outputs got=%b exp=000000000", obs); end
        reset = 1'b0;
        tick(); tick();
        obs = {busy, done, error, bus.k_out_ready, bus.src_rd_en, bus.dst_wr_en,
               bus.k_pixel_valid, bus.k_imgw_valid, bus.k_imgh_valid};
        checks++;
        if (obs !== 9'd0) begin failures++; $display("FAIL idle_outputs got=%b exp=000000000", obs); end
    endtask

    task automatic test_basic();
        int w0, r0, d0, iw0, ih0;
        bit seen;
        load_frame();
        tick();
        w0 = wr_count; r0 = rd_count; d0 = done_cnt; iw0 = imgw_hs_cnt; ih0 = imgh_hs_cnt;
        pulse_start(4, 4);
        @(negedge clock);
        checks++;
        if ({bus.k_imgw_valid, bus.k_imgh_valid} !== 2'b11 || bus.k_imgw_bits !== 16'd4 || bus.k_imgh_bits !== 16'd4) begin
            failures++;
            $display("FAIL cfg_first vld=%b%b w=%0d h=%0d exp vld=11 w=4 h=4",
                     bus.k_imgw_valid, bus.k_imgh_valid, bus.k_imgw_bits, bus.k_imgh_bits);
        end
        @(negedge clock);
        checks++;
        if ({bus.k_imgw_valid, bus.k_imgh_valid} !== 2'b01) begin
            failures++; $display("FAIL cfg_drop vld=%b%b exp=01", bus.k_imgw_valid, bus.k_imgh_valid);
        end
        wait_done(400, seen);
        tick(); tick();
        checks++;
        if (!seen) begin failures++; $display("FAIL basic_done got=0 exp=1"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dst_ram[16'(128 + i)] !== exp_px[i]) begin
                failures++; $display("FAIL basic_px%0d got=%0d exp=%0d", i, dst_ram[16'(128 + i)], exp_px[i]);
            end
        end
        checks++;
        if (dst_ram[16'h84] !== 8'hEE) begin failures++; $display("FAIL basic_no_extra got=%h exp=ee", dst_ram[16'h84]); end
        checks++;
        if (done_cnt - d0 !== 1) begin failures++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt - d0); end
        checks++;
        if (wr_count - w0 !== 4) begin failures++; $display("FAIL basic_writes got=%0d exp=4", wr_count - w0); end
        checks++;
        if (rd_count - r0 !== 16) begin failures++; $display("FAIL basic_reads got=%0d exp=16", rd_count - r0); end
        checks++;
        if (imgw_hs_cnt - iw0 !== 1 || imgh_hs_cnt - ih0 !== 1) begin
            failures++; $display("FAIL basic_cfg_hs got=%0d/%0d exp=1/1", imgw_hs_cnt - iw0, imgh_hs_cnt - ih0);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_stall();
        int w0, r0, iw0, s0, p0;
        bit seen;
        load_frame();
        ready_random = 1'b1;
        tick();
        w0 = wr_count; r0 = rd_count; iw0 = imgw_hs_cnt; s0 = stall_bad;
        pulse_start(4, 4);
        repeat (5) tick();
        pulse_start(5, 5);
        cfg_width = 16'd4; cfg_height = 16'd4;
        wait_done(1000, seen);
        tick(); tick();
        ready_random = 1'b0;
        p0 = kpix_cnt;
        checks++;
        if (!seen) begin failures++; $display("FAIL stall_done got=0 exp=1"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dst_ram[16'(128 + i)] !== exp_px[i]) begin
                failures++; $display("FAIL stall_px%0d got=%0d exp=%0d", i, dst_ram[16'(128 + i)], exp_px[i]);
            end
        end
        checks++;
        if (p0 !== 16) begin failures++; $display("FAIL stall_pixels got=%0d exp=16", p0); end
        checks++;
        if (rd_count - r0 !== 16) begin failures++; $display("FAIL stall_reads got=%0d exp=16", rd_count - r0); end
        checks++;
        if (wr_count - w0 !== 4) begin failures++; $display("FAIL stall_writes got=%0d exp=4", wr_count - w0); end
        checks++;
        if (stall_bad - s0 !== 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", stall_bad - s0); end
        checks++;
        if (imgw_hs_cnt - iw0 !== 1) begin failures++; $display("FAIL start_while_busy got=%0d exp=1", imgw_hs_cnt - iw0); end
    endtask

    task automatic test_bad_cfg();
        int r0, iw0;
        int bw [0:1] = '{2, 5};
        int bh [0:1] = '{5, 2};
        tick();
        r0 = rd_count; iw0 = imgw_hs_cnt;
        for (int k = 0; k < 2; k++) begin
            tick();
            cfg_width = 16'(bw[k]); cfg_height = 16'(bh[k]); start = 1'b1;
            @(negedge clock);
            checks++;
            if ({error, busy} !== 2'b00) begin failures++; $display("FAIL bad%0d_start_cycle err/busy=%b exp=00", k, {error, busy}); end
            tick();
            start = 1'b0;
            @(negedge clock);
            checks++;
            if ({error, busy} !== 2'b10) begin failures++; $display("FAIL bad%0d_error_pulse err/busy=%b exp=10", k, {error, busy}); end
            @(negedge clock);
            checks++;
            if ({error, busy} !== 2'b00) begin failures++; $display("FAIL bad%0d_error_end err/busy=%b exp=00", k, {error, busy}); end
        end
        tick();
        checks++;
        if (rd_count - r0 !== 0 || imgw_hs_cnt - iw0 !== 0) begin
            failures++; $display("FAIL bad_no_activity reads=%0d cfg_hs=%0d exp=0/0", rd_count - r0, imgw_hs_cnt - iw0);
        end
        cfg_width = 16'd4; cfg_height = 16'd4;
    endtask

    task automatic test_back_to_back();
        int w0, iw0, ih0, d0, r0;
        bit seen;
        bit all_seen;
        load_frame();
        tick();
        w0 = wr_count; iw0 = imgw_hs_cnt; ih0 = imgh_hs_cnt; d0 = done_cnt; r0 = rd_count;
        all_seen = 1'b1;
        for (int f = 0; f < 3; f++) begin
            pulse_start(4, 4);
            wait_done(400, seen);
            if (!seen) all_seen = 1'b0;
        end
        tick(); tick();
        checks++;
        if (!all_seen) begin failures++; $display("FAIL b2b_done got=0 exp=1"); end
        checks++;
        if (wr_count - w0 !== 12) begin failures++; $display("FAIL b2b_writes got=%0d exp=12", wr_count - w0); end
        checks++;
        if (rd_count - r0 !== 48) begin failures++; $display("FAIL b2b_reads got=%0d exp=48", rd_count - r0); end
        checks++;
        if (imgw_hs_cnt - iw0 !== 3 || imgh_hs_cnt - ih0 !== 3) begin
            failures++; $display("FAIL b2b_cfg_hs got=%0d/%0d exp=3/3", imgw_hs_cnt - iw0, imgh_hs_cnt - ih0);
        end
        checks++;
        if (done_cnt - d0 !== 3) begin failures++; $display("FAIL b2b_done_cnt got=%0d exp=3", done_cnt - d0); end
        checks++;
        if (dst_ram[16'h83] !== 8'd45) begin failures++; $display("FAIL b2b_last_px got=%0d exp=45", dst_ram[16'h83]); end
    endtask

    task automatic test_reset_mid();
        int w0, d0, e0;
        bit reached, seen;
        load_frame();
        tick();
        d0 = done_cnt; e0 = err_cnt;
        pulse_start(4, 4);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clock);
            if (kpix_cnt >= 7) reached = 1'b1;
        end
        checks++;
        if (!reached) begin failures++; $display("FAIL mid_reach_7 got=%0d exp>=7", kpix_cnt); end
        tick();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, bus.k_pixel_valid, bus.src_rd_en, bus.dst_wr_en} !== 4'b0000) begin
            failures++; $display("FAIL mid_reset_state got=%b exp=0000",
                                 {busy, bus.k_pixel_valid, bus.src_rd_en, bus.dst_wr_en});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            failures++; $display("FAIL mid_no_pulse done=%0d err=%0d exp=0/0", done_cnt - d0, err_cnt - e0);
        end
        load_frame();
        w0 = wr_count;
        pulse_start(4, 4);
        wait_done(400, seen);
        tick(); tick();
        checks++;
        if (!seen) begin failures++; $display("FAIL mid_clean_done got=0 exp=1"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dst_ram[16'(128 + i)] !== exp_px[i]) begin
                failures++; $display("FAIL mid_px%0d got=%0d exp=%0d", i, dst_ram[16'(128 + i)], exp_px[i]);
            end
        end
        checks++;
        if (wr_count - w0 !== 4) begin failures++; $display("FAIL mid_writes got=%0d exp=4", wr_count - w0); end
    endtask

`ifdef STENCIL_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int d0;
        bit seen;
        load_frame();
        never_out = 1'b1;
        tick();
        d0 = done_cnt;
        pulse_start(4, 4);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clock);
            if (error) seen = 1'b1;
        end
        tick(); tick();
        never_out = 1'b0;
        checks++;
        if (!seen) begin failures++; $display("FAIL timeout_error got=0 exp=1"); end
        checks++;
        if ({busy, bus.k_pixel_valid, bus.k_out_ready} !== 3'b000) begin
            failures++; $display("FAIL timeout_idle got=%b exp=000", {busy, bus.k_pixel_valid, bus.k_out_ready});
        end
        checks++;
        if (done_cnt - d0 !== 0) begin failures++; $display("FAIL timeout_no_done got=%0d exp=0", done_cnt - d0); end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0;
        cfg_width = 16'd4; cfg_height = 16'd4;
        cfg_src_base = 16'h0010; cfg_dst_base = 16'h0080;
        test_reset();
        test_basic();
        test_stall();
        test_bad_cfg();
        test_back_to_back();
        test_reset_mid();
`ifdef STENCIL_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
